// File: rtl/capture_readout_if.sv
// capture_readout_if: sample-in and readout-out stream signals of the capture buffer.
interface capture_readout_if #(
    parameter int size = 32
);
    logic [size-1:0] s_tdata;
    logic            s_tvalid;
    logic            s_tready;
    logic [size-1:0] m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;

    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/capture_readout.sv
// capture_readout: circular capture buffer that replays frozen samples oldest-first.
module capture_readout #(
    parameter int size   = 32,
    parameter int addr_w = 10
) (
    input  logic                clk,
    input  logic                reset,
    capture_readout_if.slave    bus,
    input  logic                start,
    input  logic                stop,
    input  logic                drain,
    input  logic                abort,
    output logic [addr_w:0]     sample_count,
    output logic                wrapped,
    output logic                done
);
    typedef enum logic [1:0] {st_idle, st_fill, st_hold, st_drain} state_t;

    localparam logic [addr_w:0] depth = {1'b1, {addr_w{1'b0}}};

    logic [size-1:0]   mem [2**addr_w];
    logic [addr_w-1:0] wr_ptr, rd_ptr;
    logic [addr_w:0]   remaining;
    state_t            state, state_nx;
    logic              wr_en, rd_en, last_hs;

    always_comb begin
        wr_en   = state == st_fill && bus.s_tvalid;
        rd_en   = state == st_drain && remaining != '0 && (!bus.m_tvalid || bus.m_tready) && !abort;
        last_hs = bus.m_tvalid && bus.m_tready && bus.m_tlast;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= st_idle;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            st_idle:  state_nx = start && !abort ? st_fill : st_idle;
            st_fill:  state_nx = abort ? st_idle : stop ? st_fill_or_hold(stop) : st_fill;
            st_hold:  state_nx = abort ? st_idle : !drain ? st_hold : sample_count != '0 ? st_drain : st_idle;
            st_drain: state_nx = abort || last_hs ? st_idle : st_drain;
            default:  state_nx = st_idle;
        endcase
    end

    function automatic state_t st_fill_or_hold(input logic s);
        return s ? st_hold : st_fill;
    endfunction

    always_comb begin
        bus.s_tready = state == st_fill;
        done         = state == st_hold;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.s_tdata;
    end

    // Output register doubles as the synchronous read port; it only advances when empty or accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            remaining    <= '0;
            sample_count <= '0;
            wrapped      <= 1'b0;
            bus.m_tdata  <= '0;
            bus.m_tvalid <= 1'b0;
            bus.m_tlast  <= 1'b0;
        end else begin
            if (abort) begin
                sample_count <= '0;
                wrapped      <= 1'b0;
            end else if (state == st_idle && start) begin
                wr_ptr       <= '0;
                sample_count <= '0;
                wrapped      <= 1'b0;
            end else if (wr_en) begin
                wr_ptr       <= wr_ptr + addr_w'(1);
                sample_count <= sample_count == depth ? sample_count : sample_count + (addr_w+1)'(1);
                wrapped      <= wrapped || &wr_ptr;
            end
            if (state == st_hold) begin
                rd_ptr    <= wrapped ? wr_ptr : '0;
                remaining <= sample_count;
            end else if (rd_en) begin
                rd_ptr    <= rd_ptr + addr_w'(1);
                remaining <= remaining - (addr_w+1)'(1);
            end
            if (rd_en) begin
                bus.m_tdata  <= mem[rd_ptr];
                bus.m_tvalid <= 1'b1;
                bus.m_tlast  <= remaining == (addr_w+1)'(1);
            end else if (abort || bus.m_tready) begin
                bus.m_tvalid <= 1'b0;
                bus.m_tlast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: queue-based model of the capture buffer checked every cycle plus directed literal checks.
module tb_capture_readout;
    localparam int depth = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, drain = 1'b0, abort = 1'b0;
    logic [3:0] sample_count;
    logic       wrapped, done;

    capture_readout_if #(.size(32)) bus ();

    capture_readout #(.size(32), .addr_w(3)) dut (
        .clk          (clk),
        .reset        (rst),
        .bus          (bus.slave),
        .start        (start),
        .stop         (stop),
        .drain        (drain),
        .abort        (abort),
        .sample_count (sample_count),
        .wrapped      (wrapped),
        .done         (done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    int          mode = 0, cnt = 0, nw = 0, dcyc = 0;
    bit          wrp = 1'b0;
    logic [31:0] hist[$], expq[$], got[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 filling, 2 frozen, 3 replaying; history kept as the last depth samples.
    always @(posedge clk) begin
        if (rst) begin
            mode = 0; cnt = 0; wrp = 1'b0; expq.delete();
        end else begin
            case (mode)
                0: if (abort) begin
                       cnt = 0; wrp = 1'b0;
                   end else if (start) begin
                       mode = 1; cnt = 0; wrp = 1'b0; nw = 0; hist.delete();
                   end
                1: if (abort) begin
                       mode = 0; cnt = 0; wrp = 1'b0;
                   end else begin
                       if (bus.s_tvalid) begin
                           hist.push_back(bus.s_tdata);
                           if (hist.size() > depth) void'(hist.pop_front());
                           nw++;
                       end
                       cnt = hist.size();
                       wrp = nw >= depth;
                       if (stop) mode = 2;
                   end
                2: if (abort) begin
                       mode = 0; cnt = 0; wrp = 1'b0;
                   end else if (drain) begin
                       if (cnt > 0) begin
                           mode = 3; expq = hist; dcyc = 0;
                       end else mode = 0;
                   end
                3: if (abort) begin
                       mode = 0; cnt = 0; wrp = 1'b0; expq.delete();
                   end else if (expq.size() == 0) mode = 0;
                   else dcyc++;
                default: mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic ev;
        ev = mode == 3 && dcyc >= 1 && expq.size() > 0;
        chk("m_tvalid", bus.m_tvalid, ev);
        if (ev) begin
            chk("m_tdata", bus.m_tdata, expq[0]);
            chk("m_tlast", bus.m_tlast, expq.size() == 1);
        end else chk("m_tlast_idle", bus.m_tlast, 0);
        chk("s_tready", bus.s_tready, mode == 1);
        chk("done", done, mode == 2);
        chk("sample_count", sample_count, cnt);
        chk("wrapped", wrapped, wrp);
        if (ev && bus.m_tvalid && bus.m_tready) begin
            got.push_back(bus.m_tdata);
            void'(expq.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v);
        bus.s_tdata = v; bus.s_tvalid = 1'b1;
        tick;
        bus.s_tvalid = 1'b0;
    endtask

    task automatic p_start; start = 1'b1; tick; start = 1'b0; endtask
    task automatic p_stop;  stop  = 1'b1; tick; stop  = 1'b0; endtask
    task automatic p_drain; drain = 1'b1; tick; drain = 1'b0; endtask
    task automatic p_abort; abort = 1'b1; tick; abort = 1'b0; endtask

    task automatic run_out(input bit rnd);
        for (int i = 0; i < 300; i++) begin
            if (rnd) bus.m_tready = 1'($urandom_range(0, 1));
            tick;
            if (mode == 0) begin
                bus.m_tready = 1'b1;
                return;
            end
        end
        bus.m_tready = 1'b1;
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: got no end of readout want idle within 300 cycles");
    endtask

    initial begin
        bus.s_tdata = '0; bus.s_tvalid = 1'b0; bus.m_tready = 1'b1;
        tick; tick;
        rst = 1'b0;
        chk("rst_m_tdata", bus.m_tdata, 0);
        chk("rst_count", sample_count, 0);
        chk("rst_tready", bus.s_tready, 0);

        // five beats, simple replay
        p_start;
        for (int i = 0; i < 5; i++) send(32'h10 + i);
        p_stop;
        chk("t1_count", sample_count, 5);
        chk("t1_wrapped", wrapped, 0);
        chk("t1_done", done, 1);
        got.delete();
        p_drain;
        run_out(1'b0);
        chk("t1_nbeats", got.size(), 5);
        chk("t1_first", got[0], 32'h10);
        chk("t1_last", got[4], 32'h14);

        // overflow keeps the newest eight
        p_start;
        for (int i = 0; i < 11; i++) send(i);
        p_stop;
        chk("t2_count", sample_count, 8);
        chk("t2_wrapped", wrapped, 1);
        got.delete();
        p_drain;
        run_out(1'b0);
        chk("t2_nbeats", got.size(), 8);
        chk("t2_first", got[0], 3);
        chk("t2_last", got[7], 10);

        // full buffer under random backpressure
        p_start;
        for (int i = 0; i < 8; i++) send(32'h100 + i);
        p_stop;
        got.delete();
        p_drain;
        run_out(1'b1);
        chk("t3_nbeats", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("t3_beat", got[i], 32'h100 + i);

        // abort discards, start+abort stays idle
        p_start;
        for (int i = 0; i < 3; i++) send(32'h55 + i);
        p_abort;
        got.delete();
        p_drain;
        tick; tick; tick;
        chk("t4_count", sample_count, 0);
        chk("t4_nbeats", got.size(), 0);
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        tick;
        chk("t4_sa_tready", bus.s_tready, 0);

        // empty hold, then stop coincident with a beat
        p_start;
        p_stop;
        chk("t5_done", done, 1);
        got.delete();
        p_drain;
        tick; tick; tick;
        chk("t5_empty_beats", got.size(), 0);
        chk("t5_done_after", done, 0);
        p_start;
        send(32'h1); send(32'h2);
        bus.s_tdata = 32'hAA; bus.s_tvalid = 1'b1; stop = 1'b1;
        tick;
        bus.s_tvalid = 1'b0; stop = 1'b0;
        chk("t5_count", sample_count, 3);
        p_drain;
        run_out(1'b0);
        chk("t5_nbeats", got.size(), 3);
        chk("t5_lastbeat", got[got.size()-1], 32'hAA);

        // reset in the middle of a readout
        p_start;
        for (int i = 0; i < 6; i++) send(32'h200 + i);
        p_stop;
        got.delete();
        p_drain;
        for (int i = 0; i < 20 && got.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("t6_two_beats", got.size(), 2);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_tvalid", bus.m_tvalid, 0);
        chk("t6_tready", bus.s_tready, 0);
        chk("t6_done", done, 0);
        chk("t6_count", sample_count, 0);
        rst = 1'b0;
        tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
